ilb_responder: RTL and testbench
================================

Name: ilb_responder

Overview:
- Target-side controller for the input line buffer (ILB). It answers the master controller's ilb_send_enable / ilb_read_enable requests with ilb_byte_sent / ilb_bytes_recieved.
- Stores incoming pixels in KERNEL_SIZE circular line buffers of IMG_WIDTH bytes each.
- On request, presents one vertical KERNEL_SIZE-pixel column to the image window shifter.
- Sits between the UART receive byte path and the image window / convolution unit.

Parameters:
- IMG_WIDTH, 64: pixels per image row; power of two not required.
- KERNEL_SIZE, 3: number of line buffers and the column height.
- DATA_WIDTH, 8: pixel width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ilb_send_enable  in  1  master request: write pixel_in (level, held until ack seen)
- ilb_read_enable  in  1  master request: fetch column (level, held until ack seen)
- pixel_in  in  DATA_WIDTH  pixel from UART receiver, valid while ilb_send_enable is high
- ilb_byte_sent  out  1  one-cycle ack, write committed
- ilb_bytes_recieved  out  1  one-cycle ack, column_out updated
- column_out  out  KERNEL_SIZE*DATA_WIDTH  column: newest row in bits [DATA_WIDTH-1:0], oldest row in the MSB byte
- window_valid  out  1  high when every row of column_out holds real pixel data
- col_ptr  out  clog2(IMG_WIDTH)  next write column (debug/status)

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - FSM to IDLE.
  - ilb_byte_sent=0, ilb_bytes_recieved=0, column_out=0, window_valid=0.
  - col_ptr=0, row_ptr=0, fill counter=0.
- Buffer RAM contents are not cleared (don't-care).
- Reset mid-transaction aborts the transaction; no ack is issued.
- FSM states: IDLE, WR_ACK, RD_ACK, WAIT_DROP.
- IDLE, ilb_send_enable=1:
  - Writes pixel_in to buf[row_ptr][col_ptr] at this edge.
  - Asserts ilb_byte_sent next cycle; goes to WR_ACK.
- IDLE, ilb_read_enable=1 (and send low):
  - Loads column_out from the last-written column lc = (col_ptr-1) mod IMG_WIDTH.
  - Byte i of column_out = buf[(row_ptr_of_lc - i) mod KERNEL_SIZE][lc].
  - Asserts ilb_bytes_recieved next cycle; goes to RD_ACK.
- Simultaneous send and read in IDLE: the write wins; the read is served once the write handshake completes.
- WR_ACK / RD_ACK:
  - The ack is high for exactly this one cycle; deassert it.
  - Go to WAIT_DROP.
- WAIT_DROP:
  - Ignore both enables until both are low for one sampled cycle, then go to IDLE.
  - This covers the master's one-cycle lag in dropping a registered enable and prevents double writes.
- Latency: request sampled at edge N; ack high during cycle N+1 to N+2. column_out is stable from N+1 until the next read.
- Pointer update on each write:
  - col_ptr increments.
  - At col_ptr=IMG_WIDTH-1 it wraps to 0, and row_ptr advances modulo KERNEL_SIZE (wraps KERNEL_SIZE-1 to 0).
- Fill counter:
  - Counts writes and saturates at (KERNEL_SIZE-1)*IMG_WIDTH+1.
  - window_valid is registered and goes high on the write that reaches saturation.
  - It stays high until reset.
- An enable deasserted before the ack has no effect: the transaction was committed at sampling.
- No back-pressure. The buffer is circular and overwrites the oldest row; there is no full/empty stall.

Test Plan:
- Reset: drive rst=1 for 2 cycles with both enables high → all outputs 0, no ack, col_ptr=0.
- Single write handshake (IMG_WIDTH=4, KERNEL_SIZE=3): write 0x11 with send held 2 cycles after ack → exactly one ilb_byte_sent pulse, col_ptr=1, only one write.
- Row wrap: write 4 pixels → col_ptr returns to 0, row_ptr=1. Write 0x20..0x23 into row 1 and 0x30 into row 2 → window_valid rises on the 9th write.
- Column read: after the above, read → ilb_bytes_recieved pulse one cycle after the request; column_out = {0x10,0x20,0x30}, MSB byte to LSB byte (oldest row in MSB).
- Simultaneous requests: send=1 and read=1 in IDLE → byte_sent pulse first; read ack only after both enables drop and read is re-asserted.
- Mid-op reset: assert rst during WR_ACK → ack cleared; later writes start at col_ptr=0 with window_valid=0.

Source files
------------

// File: rtl/ilb_responder.sv
// ilb_responder
//   Target-side controller for the input line buffer. Incoming pixels are
//   stored in KERNEL_SIZE circular line buffers of IMG_WIDTH bytes. On request,
//   one vertical KERNEL_SIZE-pixel column is presented to the window shifter.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   ilb_send_enable     request: write pixel_in (level, held until ack seen)
//   ilb_read_enable     request: fetch column (level, held until ack seen)
//   pixel_in            pixel from the UART receiver
//   ilb_byte_sent       one-cycle ack, write committed
//   ilb_bytes_recieved  one-cycle ack, column_out updated
//   column_out          newest row in the LSB byte, oldest row in the MSB byte
//   window_valid        every row of column_out holds real pixel data
//   col_ptr             next write column
//   state_dbg           current FSM state (IDLE=0, WR_ACK=1, RD_ACK=2, WAIT_DROP=3)
//
// Handshake: a request is a level held by the master. It is committed at the
// first clk edge where it is sampled in IDLE; the matching ack is high for
// exactly the following cycle. Afterwards the responder ignores both enables
// until it has sampled both low once, so an enable that the master drops one
// cycle late can never be taken as a second request. Requires IMG_WIDTH >= 2.

module ilb_responder #(
  parameter int IMG_WIDTH   = 64,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ilb_send_enable,
  input  logic                              ilb_read_enable,
  input  logic [DATA_WIDTH-1:0]             pixel_in,
  output logic                              ilb_byte_sent,
  output logic                              ilb_bytes_recieved,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] column_out,
  output logic                              window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]      col_ptr,
  output logic [1:0]                        state_dbg
);

  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int FILL_MAX = (KERNEL_SIZE - 1) * IMG_WIDTH + 1;
  localparam int FW       = $clog2(FILL_MAX + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(KERNEL_SIZE - 1);
  localparam logic [FW-1:0] FILL_SAT = FW'(FILL_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_ACK    = 2'd1,
    RD_ACK    = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [KERNEL_SIZE][IMG_WIDTH];

  logic [RW-1:0] row_ptr;
  logic [FW-1:0] fill_cnt;
  logic          do_write;
  logic          do_read;

  logic [CW-1:0]                       last_col;
  logic [RW-1:0]                       last_row;
  logic [RW-1:0]                       rd_row;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0]   rd_col;

  // Write has priority; a read seen together with a write is served on a
  // later request, after the write handshake has fully closed.
  assign do_write = (state == IDLE) && ilb_send_enable;
  assign do_read  = (state == IDLE) && ilb_read_enable && !ilb_send_enable;

  assign ilb_byte_sent      = (state == WR_ACK);
  assign ilb_bytes_recieved = (state == RD_ACK);
  assign state_dbg          = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ilb_send_enable)      state_nxt = WR_ACK;
        else if (ilb_read_enable) state_nxt = RD_ACK;
      end
      WR_ACK:    state_nxt = WAIT_DROP;
      RD_ACK:    state_nxt = WAIT_DROP;
      WAIT_DROP: begin
        if (!ilb_send_enable && !ilb_read_enable) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Buffer storage has no reset; the guard on rst keeps an aborted request
  // from landing in the buffer.
  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[row_ptr][col_ptr] <= pixel_in;
  end

  // The last written column sits one behind col_ptr. When col_ptr has just
  // wrapped to 0, that column belongs to the previous row.
  always_comb begin
    last_col = (col_ptr == '0) ? COL_LAST : col_ptr - 1'b1;
    last_row = row_ptr;
    if (col_ptr == '0) last_row = (row_ptr == '0) ? ROW_LAST : row_ptr - 1'b1;
  end

  // Walk backwards through the rows: byte 0 is the newest row, the top byte
  // the oldest.
  always_comb begin
    rd_col = '0;
    rd_row = last_row;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      rd_col[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_row][last_col];
      rd_row = (rd_row == '0) ? ROW_LAST : rd_row - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_ptr      <= '0;
      row_ptr      <= '0;
      fill_cnt     <= '0;
      window_valid <= 1'b0;
      column_out   <= '0;
    end else begin
      if (do_write) begin
        if (col_ptr == COL_LAST) begin
          col_ptr <= '0;
          row_ptr <= (row_ptr == ROW_LAST) ? '0 : row_ptr + 1'b1;
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
        if (fill_cnt != FILL_SAT) fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == FILL_SAT - 1'b1) window_valid <= 1'b1;
      end
      if (do_read) column_out <= rd_col;
    end
  end

endmodule

// File: tb/tb_ilb_responder.sv
// Bench for ilb_responder (IMG_WIDTH=4, KERNEL_SIZE=3, DATA_WIDTH=8).
// Reference model: the list of pixels written since reset. Expected column
// byte i is the pixel written i rows (i*IMG_WIDTH writes) before the newest.

module tb_ilb_responder;

  localparam int W    = 4;
  localparam int K    = 3;
  localparam int D    = 8;
  localparam int CWD  = K * D;
  localparam int SAT  = (K - 1) * W + 1;

  logic           clk;
  logic           rst;
  logic           ilb_send_enable;
  logic           ilb_read_enable;
  logic [D-1:0]   pixel_in;
  logic           ilb_byte_sent;
  logic           ilb_bytes_recieved;
  logic [CWD-1:0] column_out;
  logic           window_valid;
  logic [1:0]     col_ptr;
  logic [1:0]     state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [D-1:0]   hist[$];
  logic [CWD-1:0] exp_q[$];

  ilb_responder #(.IMG_WIDTH(W), .KERNEL_SIZE(K), .DATA_WIDTH(D)) dut (
    .clk                (clk),
    .rst                (rst),
    .ilb_send_enable    (ilb_send_enable),
    .ilb_read_enable    (ilb_read_enable),
    .pixel_in           (pixel_in),
    .ilb_byte_sent      (ilb_byte_sent),
    .ilb_bytes_recieved (ilb_bytes_recieved),
    .column_out         (column_out),
    .window_valid       (window_valid),
    .col_ptr            (col_ptr),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model helpers
  function automatic logic [1:0] exp_col_ptr();
    return 2'(hist.size() % W);
  endfunction

  function automatic logic exp_valid();
    return hist.size() >= SAT;
  endfunction

  function automatic logic [CWD-1:0] exp_column();
    logic [CWD-1:0] c;
    int n;
    c = '0;
    n = hist.size();
    for (int i = 0; i < K; i++) c[i*D +: D] = hist[n - 1 - i*W];
    return c;
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_col_ptr"}, 64'(col_ptr), 64'(exp_col_ptr()));
    check({tag, "_valid"}, 64'(window_valid), 64'(exp_valid()));
  endtask

  // both enables low: two edges close any open handshake, no ack may appear
  task automatic idle_cycles();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("idle_wr_ack", 64'(ilb_byte_sent), 64'd0);
      check("idle_rd_ack", 64'(ilb_bytes_recieved), 64'd0);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [D-1:0] px, input int hold);
    @(negedge clk);
    ilb_send_enable = 1'b1;
    pixel_in        = px;
    @(posedge clk); #1;
    hist.push_back(px);
    check("wr_ack", 64'(ilb_byte_sent), 64'd1);
    check("wr_no_rd_ack", 64'(ilb_bytes_recieved), 64'd0);
    check_status("wr");
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("wr_hold_ack", 64'(ilb_byte_sent), 64'd0);
      check("wr_hold_col_ptr", 64'(col_ptr), 64'(exp_col_ptr()));
    end
    @(negedge clk);
    ilb_send_enable = 1'b0;
    pixel_in        = $urandom_range(0, 255);
    idle_cycles();
    check_status("wr_after");
  endtask

  task automatic do_read(input int hold);
    logic [CWD-1:0] exp;
    @(negedge clk);
    ilb_read_enable = 1'b1;
    exp_q.push_back(exp_column());
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    check("rd_ack", 64'(ilb_bytes_recieved), 64'd1);
    check("rd_no_wr_ack", 64'(ilb_byte_sent), 64'd0);
    check("rd_column", 64'(column_out), 64'(exp));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("rd_hold_ack", 64'(ilb_bytes_recieved), 64'd0);
    end
    @(negedge clk);
    ilb_read_enable = 1'b0;
    idle_cycles();
    check("rd_column_stable", 64'(column_out), 64'(exp));
    check_status("rd_after");
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  initial begin
    rst             = 1'b1;
    ilb_send_enable = 1'b1;
    ilb_read_enable = 1'b1;
    pixel_in        = 8'hAA;

    // reset with both enables high
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_wr_ack", 64'(ilb_byte_sent), 64'd0);
      check("rst_rd_ack", 64'(ilb_bytes_recieved), 64'd0);
      check("rst_column", 64'(column_out), 64'd0);
      check("rst_valid", 64'(window_valid), 64'd0);
      check("rst_col_ptr", 64'(col_ptr), 64'd0);
    end
    @(negedge clk);
    rst             = 1'b0;
    ilb_send_enable = 1'b0;
    ilb_read_enable = 1'b0;
    idle_cycles();
    check("post_rst_col_ptr", 64'(col_ptr), 64'd0);

    // single write, send held 2 cycles past the ack
    do_write(8'h11, 2);
    check("single_col_ptr", 64'(col_ptr), 64'd1);

    // row fill: row0 0x10.., row1 0x20.., row2 0x30
    do_reset(1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c < SAT) begin
          if (r * W + c == SAT - 1)
            check("valid_before_last", 64'(window_valid), 64'd0);
          do_write(8'(16 * (r + 1) + c), c % 2);
          if (r * W + c == W - 1)
            check("row_wrap_col_ptr", 64'(col_ptr), 64'd0);
        end
    check("valid_at_sat", 64'(window_valid), 64'd1);
    do_read(1);
    check("directed_column", 64'(column_out), 64'h102030);

    // simultaneous send and read: the write wins
    @(negedge clk);
    ilb_send_enable = 1'b1;
    ilb_read_enable = 1'b1;
    pixel_in        = 8'h31;
    @(posedge clk); #1;
    hist.push_back(8'h31);
    check("sim_wr_ack", 64'(ilb_byte_sent), 64'd1);
    check("sim_no_rd_ack", 64'(ilb_bytes_recieved), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("sim_hold_rd_ack", 64'(ilb_bytes_recieved), 64'd0);
      check("sim_hold_wr_ack", 64'(ilb_byte_sent), 64'd0);
    end
    @(negedge clk);
    ilb_send_enable = 1'b0;
    ilb_read_enable = 1'b0;
    idle_cycles();
    check_status("sim");
    do_read(0);
    check("sim_column", 64'(column_out), 64'h112131);

    // randomized traffic against the history model
    for (int t = 0; t < 80; t++) begin
      if (hist.size() >= SAT && $urandom_range(0, 2) == 0)
        do_read($urandom_range(0, 2));
      else
        do_write(8'($urandom_range(0, 255)), $urandom_range(0, 2));
    end

    // reset during the write ack aborts the handshake
    @(negedge clk);
    ilb_send_enable = 1'b1;
    pixel_in        = 8'h5A;
    @(posedge clk); #1;
    check("midrst_ack_seen", 64'(ilb_byte_sent), 64'd1);
    @(negedge clk);
    rst             = 1'b1;
    ilb_send_enable = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack_cleared", 64'(ilb_byte_sent), 64'd0);
    check("midrst_col_ptr", 64'(col_ptr), 64'd0);
    check("midrst_valid", 64'(window_valid), 64'd0);
    check("midrst_column", 64'(column_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    idle_cycles();
    do_write(8'h66, 0);
    check("midrst_restart_col_ptr", 64'(col_ptr), 64'd1);
    check("midrst_restart_valid", 64'(window_valid), 64'd0);

    // refill after reset and read once more
    for (int t = 0; t < SAT + 2; t++) do_write(8'($urandom_range(0, 255)), t % 3);
    do_read(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
